// File: rtl/sram_array_ctrl.sv
// Precharge / bitline-drive / wordline sequencer for a single-port 6T SRAM array, one word per row.
// Define SRAM_CTRL_PARITY_EN to add an even-parity column checked on reads.
module sram_array_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int ROWS    = 16,
  parameter int DATA_W  = 8,
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2,
`ifdef SRAM_CTRL_PARITY_EN
  localparam int BW = DATA_W + 1
`else
  localparam int BW = DATA_W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ROWS-1:0]   wl,
  output logic              precharge,
  output logic              bl_drive_en,
  output logic [BW-1:0]     bl_wdata,
  output logic [BW-1:0]     blb_wdata,
  input  logic [BW-1:0]     bl_rdata
);

  localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [ADDR_W:0] ROWS_L = (ADDR_W + 1)'(ROWS);

  typedef enum logic [2:0] {IDLE, PRE, DRIVE, ACCESS, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ROWS-1:0]     wl_q, wl_d;
  logic                pre_q, pre_d;
  logic                drive_q, drive_d;
  logic [BW-1:0]       bl_q, bl_d;
  logic [BW-1:0]       blb_q, blb_d;

  logic                accept, in_range, read_cap, parity_bad;
  logic [BW-1:0]       word_d;

  assign accept   = ready_q && req_valid;
  assign in_range = {1'b0, req_addr} < ROWS_L;

  // Outputs are registered from the next state so each pin reflects the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wl_q        <= '0;
      pre_q       <= 1'b0;
      drive_q     <= 1'b0;
      bl_q        <= '0;
      blb_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wl_q        <= wl_d;
      pre_q       <= pre_d;
      drive_q     <= drive_d;
      bl_q        <= bl_d;
      blb_q       <= blb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = !in_range;
          state_d = in_range ? PRE : DONE;
        end
      end
      PRE:     if (cnt_q == CNT_W'(PRE_CYC - 1)) state_d = we_q ? DRIVE : ACCESS;
      DRIVE:   state_d = ACCESS;
      ACCESS:  if (cnt_q == CNT_W'(WL_CYC - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q && state_q != IDLE) ? cnt_q + 1'b1 : '0;
  end

`ifdef SRAM_CTRL_PARITY_EN
  assign word_d     = {^wdata_d, wdata_d};
  assign parity_bad = read_cap && (^bl_rdata);
`else
  assign word_d     = wdata_d;
  assign parity_bad = 1'b0;
`endif

  // The array is only sensed on the last wordline cycle of a read.
  assign read_cap = (state_q == ACCESS) && (state_d == DONE) && !we_q;

  always_comb begin
    ready_d     = (state_d == IDLE);
    pre_d       = (state_d == PRE);
    drive_d     = (state_d == DRIVE) || ((state_d == ACCESS) && we_d);
    bl_d        = drive_d ? word_d : '0;
    blb_d       = drive_d ? ~word_d : '0;
    wl_d        = '0;
    for (int i = 0; i < ROWS; i++) begin
      wl_d[i] = (state_d == ACCESS) && (addr_d == ADDR_W'(i));
    end
    rsp_valid_d = (state_d == DONE);
    rsp_we_d    = (state_d == DONE) && we_d;
    rsp_err_d   = (state_d == DONE) && (err_d || parity_bad);
    rsp_rdata_d = read_cap ? bl_rdata[DATA_W-1:0] : '0;
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_we      = rsp_we_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign wl          = wl_q;
  assign precharge   = pre_q;
  assign bl_drive_en = drive_q;
  assign bl_wdata    = bl_q;
  assign blb_wdata   = blb_q;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: behavioural 6T array model, response scoreboard and per-cycle invariant monitor.
// Build with SRAM_CTRL_PARITY_EN defined to also exercise the parity column.
module tb_sram_array_ctrl;

  localparam int ADDR_W  = 4;
  localparam int ROWS    = 12;
  localparam int DATA_W  = 8;
  localparam int PRE_CYC = 1;
  localparam int WL_CYC  = 2;
`ifdef SRAM_CTRL_PARITY_EN
  localparam int BW = DATA_W + 1;
`else
  localparam int BW = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid, rsp_we, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ROWS-1:0]   wl;
  logic              precharge, bl_drive_en;
  logic [BW-1:0]     bl_wdata, blb_wdata, bl_rdata;

  sram_array_ctrl #(
    .ADDR_W(ADDR_W), .ROWS(ROWS), .DATA_W(DATA_W), .PRE_CYC(PRE_CYC), .WL_CYC(WL_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wl(wl), .precharge(precharge), .bl_drive_en(bl_drive_en),
    .bl_wdata(bl_wdata), .blb_wdata(blb_wdata), .bl_rdata(bl_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] expRdata;
    logic              expErr;
  } vec_t;

  typedef struct {
    logic              we;
    logic [DATA_W-1:0] rdata;
    logic              err;
    int                lat;
    int                acceptCyc;
  } exp_t;

  exp_t          sbq[$];
  exp_t          popped;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            busy = 1'b0;
  int            busyCyc = 0;
  bit            curWe = 1'b0;
  int            wlRises = 0;
  int            wlLow = 0;
  bit            seenWl = 1'b0;
  int            rspCount = 0;
  logic [ROWS-1:0] prevWl = '0;
  logic [BW-1:0] invBl;
  logic [BW-1:0] mem [ROWS] = '{default: '0};
  bit            flipParity = 1'b0;
  logic [BW-1:0] flipMask;
  vec_t          vecs[14];

`ifdef SRAM_CTRL_PARITY_EN
  assign flipMask = {flipParity, {DATA_W{1'b0}}};
`else
  assign flipMask = '0;
`endif

  // Cell latches whatever the complementary bitlines carry while its wordline is high.
  always @(negedge clk) begin
    if (bl_drive_en && (blb_wdata == ~bl_wdata)) begin
      for (int i = 0; i < ROWS; i++) begin
        if (wl[i]) mem[i] = bl_wdata;
      end
    end
  end

  always_comb begin
    bl_rdata = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (wl[i]) bl_rdata = mem[i] ^ flipMask;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Invariants and scoreboard pops, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("wl_onehot0", 32'($onehot0(wl)), 1);
      if (precharge) checkOutput("precharge_exclusive", 32'(bl_drive_en || (|wl)), 0);
      if ((|wl) && bl_drive_en) checkOutput("drive_with_wl_only_on_write", 32'(curWe), 1);
      if (bl_drive_en) begin
        invBl = ~bl_wdata;
        checkOutput("blb_is_inverse", 32'(blb_wdata), 32'(invBl));
      end
      if (busy && cyc > busyCyc) checkOutput("ready_low_while_busy", 32'(req_ready), 0);
      if (busy && !curWe) checkOutput("no_drive_on_read", 32'(bl_drive_en), 0);
      if ((|wl) && prevWl == '0) begin
        wlRises++;
        if (seenWl) checkOutput("wl_gap_ge2", 32'(wlLow >= 2), 1);
        seenWl = 1'b1;
        wlLow  = 0;
      end else if (wl == '0) begin
        wlLow++;
      end
      if (rsp_valid) begin
        rspCount++;
        if (sbq.size() == 0) begin
          checkOutput("unexpected_rsp", 32'(rsp_valid), 0);
        end else begin
          popped = sbq.pop_front();
          checkOutput("rsp_we", 32'(rsp_we), 32'(popped.we));
          checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(popped.rdata));
          checkOutput("rsp_err", 32'(rsp_err), 32'(popped.err));
          checkOutput("rsp_latency", 32'(cyc - popped.acceptCyc), 32'(popped.lat));
          busy = 1'b0;
        end
      end
    end else begin
      busy = 1'b0;
    end
    prevWl = wl;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input vec_t v, input bit keepValid);
    exp_t e;
    bit   ok;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("accept_timeout", 32'(ok), 1);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    e.we        = v.we;
    e.rdata     = v.expRdata;
    e.err       = v.expErr;
    e.lat       = v.expErr ? 1 : (v.we ? PRE_CYC + WL_CYC + 2 : PRE_CYC + WL_CYC + 1);
    e.acceptCyc = cyc;
    sbq.push_back(e);
    busy    = 1'b1;
    busyCyc = cyc;
    curWe   = v.we;
    @(posedge clk);
    #1;
    if (!keepValid) req_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int k = 0; k < 60; k++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("drain_timeout", 32'(sbq.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   rises0;
    int   rsp0;
    logic [BW-1:0] expBlb;
    logic [BW-1:0] before5;

    vecs[0]  = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};
    vecs[1]  = '{1'b1, 4'd11, 8'h3C, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 4'd11, 8'h00, 8'h3C, 1'b0};
    vecs[3]  = '{1'b0, 4'd12, 8'h00, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 4'd0,  8'hFF, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  8'h00, 8'hFF, 1'b0};
    vecs[6]  = '{1'b1, 4'd15, 8'h12, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 4'd5,  8'h66, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 4'd5,  8'h00, 8'h66, 1'b0};
    vecs[9]  = '{1'b1, 4'd1,  8'h00, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 4'd1,  8'h00, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 4'd2,  8'h81, 8'h00, 1'b0};
    vecs[12] = '{1'b0, 4'd2,  8'h00, 8'h81, 1'b0};
    vecs[13] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 1);
    checkOutput("reset_wl", 32'(wl), 0);
    checkOutput("reset_precharge", 32'(precharge), 0);
    checkOutput("reset_drive", 32'(bl_drive_en), 0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("reset_bl_wdata", 32'(bl_wdata), 0);
    @(posedge clk);
    #1;

    // Cycle-by-cycle trace of a write: PRE, DRIVE, ACCESS x2, DONE.
`ifdef SRAM_CTRL_PARITY_EN
    expBlb = 9'h15A;
`else
    expBlb = 8'h5A;
`endif
    applyStimulus('{1'b1, 4'd3, 8'hA5, 8'h00, 1'b0}, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("wtrace%0d_precharge", k), 32'(precharge), 32'(k == 1));
      checkOutput($sformatf("wtrace%0d_drive", k), 32'(bl_drive_en), 32'(k >= 2 && k <= 4));
      checkOutput($sformatf("wtrace%0d_wl", k), 32'(wl), (k == 3 || k == 4) ? 32'h008 : 32'h0);
      checkOutput($sformatf("wtrace%0d_bl", k), 32'(bl_wdata), (k >= 2 && k <= 4) ? 32'hA5 : 32'h0);
      checkOutput($sformatf("wtrace%0d_blb", k), 32'(blb_wdata), (k >= 2 && k <= 4) ? 32'(expBlb) : 32'h0);
      checkOutput($sformatf("wtrace%0d_rsp_valid", k), 32'(rsp_valid), 32'(k == 5));
    end
    waitDrain();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], 1'b0);
      waitDrain();
    end

    rises0 = wlRises;
    applyStimulus('{1'b0, 4'd13, 8'h00, 8'h00, 1'b1}, 1'b0);
    waitDrain();
    checkOutput("oob_no_wl", 32'(wlRises), 32'(rises0));

    // Back-to-back reads with req_valid held high.
    rsp0 = rspCount;
    applyStimulus('{1'b0, 4'd0, 8'h00, 8'hFF, 1'b0}, 1'b1);
    applyStimulus('{1'b0, 4'd1, 8'h00, 8'h00, 1'b0}, 1'b1);
    applyStimulus('{1'b0, 4'd2, 8'h00, 8'h81, 1'b0}, 1'b0);
    waitDrain();
    checkOutput("b2b_pulse_count", 32'(rspCount - rsp0), 3);

    // Reset during the DRIVE cycle of a write: no wordline, no response, cell keeps old value.
    before5 = mem[5];
    checkOutput("abort_prior_cell", 32'(before5), 32'h66);
    rises0 = wlRises;
    rsp0   = rspCount;
    applyStimulus('{1'b1, 4'd5, 8'h99, 8'h00, 1'b0}, 1'b0);
    begin
      bit found = 1'b0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (bl_drive_en && wl == '0) begin
          found = 1'b1;
          break;
        end
      end
      checkOutput("abort_drive_seen", 32'(found), 1);
    end
    #1 rst = 1'b1;
    sbq.delete();
    busy = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("abort_no_wl", 32'(wlRises), 32'(rises0));
    checkOutput("abort_no_rsp", 32'(rspCount), 32'(rsp0));
    checkOutput("abort_cell_unchanged", 32'(mem[5]), 32'(before5));
    applyStimulus('{1'b0, 4'd5, 8'h00, 8'h66, 1'b0}, 1'b0);
    waitDrain();

`ifdef SRAM_CTRL_PARITY_EN
    applyStimulus('{1'b1, 4'd4, 8'h07, 8'h00, 1'b0}, 1'b0);
    waitDrain();
    checkOutput("parity_cell", 32'(mem[4]), 32'h107);
    flipParity = 1'b1;
    applyStimulus('{1'b0, 4'd4, 8'h00, 8'h07, 1'b1}, 1'b0);
    waitDrain();
    flipParity = 1'b0;
    applyStimulus('{1'b0, 4'd4, 8'h00, 8'h07, 1'b0}, 1'b0);
    waitDrain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
